nn_layer_sequencer: RTL and testbench

Controller that sequences the floating-point multiply-accumulate neuron datapath (FloatMul, AdditionSubtraction, weight RAM, bias RAM) through one full layer. For each output neuron it generates weight addresses, gates the input stream, and accounts for the mul/add pipeline latency. It then strobes bias-add and ReLU, and hands the result downstream over a valid/ready handshake. It sits between the input-vector source and the per-neuron datapath, replacing the free-running external `counter`.

---
 rtl/nn_layer_sequencer_pkg.sv | 24 ++
 rtl/nn_layer_sequencer_if.sv | 33 +++
 rtl/nn_layer_sequencer_beat_counter.sv | 45 ++++
 rtl/nn_layer_sequencer.sv | 151 +++++++++++++++
 tb/tb_nn_layer_sequencer.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_layer_sequencer_pkg.sv
// Shared types and default constants for the neuron-layer sequencer.
package nn_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        MAC   = 3'd2,
        DRAIN = 3'd3,
        BIAS  = 3'd4,
        RELU  = 3'd5,
        OUT   = 3'd6
    } seq_state_t;

    localparam int NN_N           = 12288;
    localparam int NN_ADDR_W      = 14;
    localparam int NN_PIPE_LAT    = 2;
    localparam int NN_NUM_NEURONS = 16;

    // Counter width that stays at least one bit for degenerate sizes of 1.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/nn_layer_sequencer_if.sv
// Handshake and datapath-control bundle between the sequencer and its surroundings.
interface nn_layer_sequencer_if
    import nn_pkg::*;
#(
    parameter int ADDR_W = NN_ADDR_W,
    parameter int IDX_W  = 4
);
    logic              start;
    logic              busy;
    logic              x_valid;
    logic              x_ready;
    logic [ADDR_W-1:0] w_addr;
    logic [IDX_W-1:0]  neuron_idx;
    logic              mac_en;
    logic              acc_clr;
    logic              bias_en;
    logic              relu_en;
    logic              out_valid;
    logic              out_ready;
    logic              done;

    modport master (
        input  start, x_valid, out_ready,
        output busy, x_ready, w_addr, neuron_idx, mac_en,
               acc_clr, bias_en, relu_en, out_valid, done
    );

    modport slave (
        output start, x_valid, out_ready,
        input  busy, x_ready, w_addr, neuron_idx, mac_en,
               acc_clr, bias_en, relu_en, out_valid, done
    );
endinterface

// File: rtl/nn_layer_sequencer_beat_counter.sv
// Up-counter with synchronous clear, enable and a terminal flag at LIMIT-1; wraps to 0 after it.
module nn_beat_counter
    import nn_pkg::*;
#(
    parameter int LIMIT = NN_N,
    parameter int WIDTH = NN_ADDR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             last_o
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign last_o  = (count_q == WIDTH'(LIMIT - 1));
    assign count_o = count_q;

    // Next count: clear wins over enable.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = {WIDTH{1'b0}};
        end else if (en_i) begin
            if (last_o) begin
                count_d = {WIDTH{1'b0}};
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/nn_layer_sequencer.sv
// Layer sequencer: steps the MAC neuron datapath through every neuron of one layer.
module nn_layer_sequencer
    import nn_pkg::*;
#(
    parameter int N           = NN_N,
    parameter int NUM_NEURONS = NN_NUM_NEURONS,
    parameter int ADDR_W      = NN_ADDR_W,
    parameter int PIPE_LAT    = NN_PIPE_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    nn_layer_sequencer_if.master  bus
);
    localparam int IDX_W   = clog2_min1(NUM_NEURONS);
    localparam int DRAIN_W = clog2_min1(PIPE_LAT);

    seq_state_t         state_q;
    logic               busy_q;
    logic               x_ready_q;
    logic               acc_clr_q;
    logic               bias_en_q;
    logic               relu_en_q;
    logic               out_valid_q;
    logic               done_q;
    logic [DRAIN_W-1:0] drain_q;

    logic [ADDR_W-1:0]  w_addr_s;
    logic               w_last_s;
    logic [IDX_W-1:0]   idx_s;
    logic               idx_last_s;
    logic               mac_en_s;
    logic               handshake_s;
    logic               w_clr_s;
    logic               w_en_s;
    logic               idx_clr_s;

    assign mac_en_s    = bus.x_valid & x_ready_q;
    assign handshake_s = out_valid_q & bus.out_ready;
    // The weight index sits at N-1 after the final beat instead of wrapping.
    assign w_clr_s     = (state_q != MAC);
    assign w_en_s      = mac_en_s & ~w_last_s;
    assign idx_clr_s   = (state_q == IDLE);

    nn_beat_counter #(.LIMIT(N), .WIDTH(ADDR_W)) u_w_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (w_clr_s),
        .en_i    (w_en_s),
        .count_o (w_addr_s),
        .last_o  (w_last_s)
    );

    nn_beat_counter #(.LIMIT(NUM_NEURONS), .WIDTH(IDX_W)) u_idx_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (idx_clr_s),
        .en_i    (handshake_s),
        .count_o (idx_s),
        .last_o  (idx_last_s)
    );

    // Sequencer state and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            x_ready_q   <= 1'b0;
            acc_clr_q   <= 1'b0;
            bias_en_q   <= 1'b0;
            relu_en_q   <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            drain_q     <= {DRAIN_W{1'b0}};
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q   <= CLEAR;
                        busy_q    <= 1'b1;
                        acc_clr_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    state_q   <= MAC;
                    acc_clr_q <= 1'b0;
                    x_ready_q <= 1'b1;
                end
                MAC: begin
                    if (mac_en_s && w_last_s) begin
                        state_q   <= DRAIN;
                        x_ready_q <= 1'b0;
                        drain_q   <= DRAIN_W'(PIPE_LAT - 1);
                    end
                end
                DRAIN: begin
                    if (drain_q == {DRAIN_W{1'b0}}) begin
                        state_q   <= BIAS;
                        bias_en_q <= 1'b1;
                    end else begin
                        drain_q <= drain_q - DRAIN_W'(1);
                    end
                end
                BIAS: begin
                    state_q   <= RELU;
                    bias_en_q <= 1'b0;
                    relu_en_q <= 1'b1;
                end
                RELU: begin
                    state_q     <= OUT;
                    relu_en_q   <= 1'b0;
                    out_valid_q <= 1'b1;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (idx_last_s) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= CLEAR;
                            acc_clr_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    x_ready_q   <= 1'b0;
                    acc_clr_q   <= 1'b0;
                    bias_en_q   <= 1'b0;
                    relu_en_q   <= 1'b0;
                    out_valid_q <= 1'b0;
                    drain_q     <= {DRAIN_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.x_ready    = x_ready_q;
    assign bus.w_addr     = w_addr_s;
    assign bus.neuron_idx = idx_s;
    assign bus.mac_en     = mac_en_s;
    assign bus.acc_clr    = acc_clr_q;
    assign bus.bias_en    = bias_en_q;
    assign bus.relu_en    = relu_en_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Self-checking bench: a cycle timeline built from the layer rules is compared with both DUT instances.
module tb_nn_layer_sequencer;
    localparam int AN = 4, ANN = 2, APL = 2, AAW = 3, AIW = 1;
    localparam int BN = 1, BNN = 1, BPL = 1, BAW = 1, BIW = 1;
    localparam int MAXC = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nn_layer_sequencer_if #(.ADDR_W(AAW), .IDX_W(AIW)) bus_a ();
    nn_layer_sequencer_if #(.ADDR_W(BAW), .IDX_W(BIW)) bus_b ();

    nn_layer_sequencer #(.N(AN), .NUM_NEURONS(ANN), .ADDR_W(AAW), .PIPE_LAT(APL)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a));
    nn_layer_sequencer #(.N(BN), .NUM_NEURONS(BNN), .ADDR_W(BAW), .PIPE_LAT(BPL)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b));

    int total = 0;
    int bad   = 0;

    // Stimulus per cycle, expected timeline and observed samples.
    // Control vector bits: {busy, x_ready, acc_clr, bias_en, relu_en, out_valid, done, mac_en}
    bit          st [MAXC];
    bit          xv [MAXC];
    bit          ordy [MAXC];
    logic [7:0]  e_ctl [MAXC];
    logic [31:0] e_w [MAXC];
    bit          e_wchk [MAXC];
    logic [31:0] e_n [MAXC];
    int          e_len;
    logic [7:0]  o_ctl [MAXC];
    logic [31:0] o_w [MAXC];
    logic [31:0] o_n [MAXC];

    task automatic gen_stim(input int mode_x, input int mode_o);
        for (int i = 0; i < MAXC; i++) begin
            st[i] = 1'b0;
            case (mode_x)
                0:       xv[i] = 1'b1;
                1:       xv[i] = ((i % 3) == 2);
                default: xv[i] = 1'($urandom_range(0, 1));
            endcase
            ordy[i] = (mode_o == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        st[0] = 1'b1;
    endtask

    // Layer timeline: cycle 0 is the IDLE cycle carrying start, cycle 1 the first CLEAR.
    task automatic build_model(input int n, input int nn, input int pl, input int hold0);
        int c, beats, h;
        for (int i = 0; i < MAXC; i++) begin
            e_ctl[i] = 8'h00; e_w[i] = 32'd0; e_wchk[i] = 1'b0; e_n[i] = 32'd0;
        end
        c = 1;
        for (int k = 0; k < nn; k++) begin
            e_ctl[c] = 8'b1010_0000; e_wchk[c] = 1'b1; e_w[c] = 32'd0; e_n[c] = k; c++;
            beats = 0;
            while (beats < n && c < MAXC - 8) begin
                e_ctl[c] = {7'b1100_000, xv[c]}; e_wchk[c] = 1'b1; e_w[c] = beats; e_n[c] = k;
                if (xv[c]) beats++;
                c++;
            end
            for (int d = 0; d < pl; d++) begin
                e_ctl[c] = 8'b1000_0000; e_n[c] = k; c++;
            end
            e_ctl[c] = 8'b1001_0000; e_n[c] = k; c++;
            e_ctl[c] = 8'b1000_1000; e_n[c] = k; c++;
            h = 0;
            while (c < MAXC - 4) begin
                if (k == 0 && h < hold0) ordy[c] = 1'b0;
                e_ctl[c] = 8'b1000_0100; e_n[c] = k; h++;
                if (ordy[c]) begin
                    c++;
                    break;
                end
                c++;
            end
        end
        e_ctl[c] = 8'b0000_0010; e_n[c] = 32'd0; c++;
        e_len = c + 1;
    endtask

    task automatic run_a(input int len, input int rst_at);
        for (int c = 0; c < len; c++) begin
            @(posedge clk); #1;
            rst = (c == rst_at);
            bus_a.start = st[c]; bus_a.x_valid = xv[c]; bus_a.out_ready = ordy[c];
            @(negedge clk);
            o_ctl[c] = {bus_a.busy, bus_a.x_ready, bus_a.acc_clr, bus_a.bias_en,
                        bus_a.relu_en, bus_a.out_valid, bus_a.done, bus_a.mac_en};
            o_w[c] = 32'(bus_a.w_addr);
            o_n[c] = 32'(bus_a.neuron_idx);
        end
        rst = 1'b0; bus_a.start = 1'b0; bus_a.x_valid = 1'b0; bus_a.out_ready = 1'b0;
    endtask

    task automatic run_b(input int len);
        for (int c = 0; c < len; c++) begin
            @(posedge clk); #1;
            bus_b.start = st[c]; bus_b.x_valid = xv[c]; bus_b.out_ready = ordy[c];
            @(negedge clk);
            o_ctl[c] = {bus_b.busy, bus_b.x_ready, bus_b.acc_clr, bus_b.bias_en,
                        bus_b.relu_en, bus_b.out_valid, bus_b.done, bus_b.mac_en};
            o_w[c] = 32'(bus_b.w_addr);
            o_n[c] = 32'(bus_b.neuron_idx);
        end
        bus_b.start = 1'b0; bus_b.x_valid = 1'b0; bus_b.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus_a.busy, bus_a.x_ready, bus_a.acc_clr, bus_a.bias_en, bus_a.relu_en,
             bus_a.out_valid, bus_a.done, bus_a.mac_en, bus_a.w_addr, bus_a.neuron_idx} !== 12'h000) begin
            bad++; $display("FAIL reset_a outputs got=%b want=0", {bus_a.busy, bus_a.x_ready,
                bus_a.acc_clr, bus_a.bias_en, bus_a.relu_en, bus_a.out_valid, bus_a.done,
                bus_a.mac_en, bus_a.w_addr, bus_a.neuron_idx});
        end
        total++;
        if ({bus_b.busy, bus_b.x_ready, bus_b.acc_clr, bus_b.bias_en, bus_b.relu_en,
             bus_b.out_valid, bus_b.done, bus_b.mac_en, bus_b.w_addr, bus_b.neuron_idx} !== 10'h000) begin
            bad++; $display("FAIL reset_b outputs got=%b want=0", {bus_b.busy, bus_b.x_ready,
                bus_b.acc_clr, bus_b.bias_en, bus_b.relu_en, bus_b.out_valid, bus_b.done,
                bus_b.mac_en, bus_b.w_addr, bus_b.neuron_idx});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; bus_a.start = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0; bus_a.start = 1'b0;
        @(negedge clk);
        total++;
        if ({bus_a.busy, bus_a.acc_clr} !== 2'b00) begin
            bad++; $display("FAIL rst_beats_start busy_accclr got=%b want=00", {bus_a.busy, bus_a.acc_clr});
        end
    endtask

    task automatic test_abort();
        gen_stim(0, 0);
        build_model(AN, ANN, APL, 0);
        for (int c = 15; c < 18; c++) begin
            e_ctl[c] = 8'h00; e_wchk[c] = 1'b1; e_w[c] = 32'd0; e_n[c] = 32'd0;
        end
        e_len = 18;
        run_a(e_len, 14);
        for (int c = 0; c < e_len; c++) begin
            total++;
            if (o_ctl[c] !== e_ctl[c]) begin bad++; $display("FAIL abort ctl c=%0d got=%b want=%b", c, o_ctl[c], e_ctl[c]); end
            if (e_wchk[c]) begin
                total++;
                if (o_w[c] !== e_w[c]) begin bad++; $display("FAIL abort w_addr c=%0d got=%0d want=%0d", c, o_w[c], e_w[c]); end
            end
            total++;
            if (o_n[c] !== e_n[c]) begin bad++; $display("FAIL abort neuron_idx c=%0d got=%0d want=%0d", c, o_n[c], e_n[c]); end
        end
    endtask

    task automatic test_continuous();
        int done_at, macs;
        gen_stim(0, 0);
        build_model(AN, ANN, APL, 0);
        run_a(e_len, -1);
        done_at = -1; macs = 0;
        for (int c = 0; c < e_len; c++) begin
            if (o_ctl[c][1] === 1'b1 && done_at < 0) done_at = c;
            if (o_ctl[c][0] === 1'b1) macs++;
            total++;
            if (o_ctl[c] !== e_ctl[c]) begin bad++; $display("FAIL cont ctl c=%0d got=%b want=%b", c, o_ctl[c], e_ctl[c]); end
            if (e_wchk[c]) begin
                total++;
                if (o_w[c] !== e_w[c]) begin bad++; $display("FAIL cont w_addr c=%0d got=%0d want=%0d", c, o_w[c], e_w[c]); end
            end
            total++;
            if (o_n[c] !== e_n[c]) begin bad++; $display("FAIL cont neuron_idx c=%0d got=%0d want=%0d", c, o_n[c], e_n[c]); end
        end
        total++;
        if (done_at != 1 + ANN * (AN + APL + 4)) begin
            bad++; $display("FAIL cont done_cycle got=%0d want=%0d", done_at, 1 + ANN * (AN + APL + 4));
        end
        total++;
        if (macs != ANN * AN) begin bad++; $display("FAIL cont mac_count got=%0d want=%0d", macs, ANN * AN); end
    endtask

    task automatic test_gapped_input();
        int macs;
        gen_stim(1, 0);
        build_model(AN, ANN, APL, 0);
        run_a(e_len, -1);
        macs = 0;
        for (int c = 0; c < e_len; c++) begin
            if (o_ctl[c][0] === 1'b1) macs++;
            total++;
            if (o_ctl[c] !== e_ctl[c]) begin bad++; $display("FAIL gap ctl c=%0d got=%b want=%b", c, o_ctl[c], e_ctl[c]); end
            if (e_wchk[c]) begin
                total++;
                if (o_w[c] !== e_w[c]) begin bad++; $display("FAIL gap w_addr c=%0d got=%0d want=%0d", c, o_w[c], e_w[c]); end
            end
        end
        total++;
        if (macs != ANN * AN) begin bad++; $display("FAIL gap mac_count got=%0d want=%0d", macs, ANN * AN); end
    endtask

    task automatic test_out_backpressure();
        int ov0;
        gen_stim(0, 0);
        build_model(AN, ANN, APL, 5);
        run_a(e_len, -1);
        ov0 = 0;
        for (int c = 0; c < e_len; c++) begin
            if (o_ctl[c][2] === 1'b1 && o_n[c] === 32'd0) ov0++;
            total++;
            if (o_ctl[c] !== e_ctl[c]) begin bad++; $display("FAIL bp ctl c=%0d got=%b want=%b", c, o_ctl[c], e_ctl[c]); end
            total++;
            if (o_n[c] !== e_n[c]) begin bad++; $display("FAIL bp neuron_idx c=%0d got=%0d want=%0d", c, o_n[c], e_n[c]); end
        end
        total++;
        if (ov0 != 6) begin bad++; $display("FAIL bp out_valid_cycles got=%0d want=6", ov0); end
    endtask

    task automatic test_ignored_inputs();
        int macs;
        repeat (3) begin
            gen_stim(2, 2);
            build_model(AN, ANN, APL, 0);
            for (int c = 1; c < e_len; c++) begin
                if (e_ctl[c][7]) st[c] = 1'($urandom_range(0, 1));
            end
            run_a(e_len, -1);
            macs = 0;
            for (int c = 0; c < e_len; c++) begin
                if (o_ctl[c][0] === 1'b1) macs++;
                total++;
                if (o_ctl[c] !== e_ctl[c]) begin bad++; $display("FAIL rnd ctl c=%0d got=%b want=%b", c, o_ctl[c], e_ctl[c]); end
                if (e_wchk[c]) begin
                    total++;
                    if (o_w[c] !== e_w[c]) begin bad++; $display("FAIL rnd w_addr c=%0d got=%0d want=%0d", c, o_w[c], e_w[c]); end
                end
                total++;
                if (o_n[c] !== e_n[c]) begin bad++; $display("FAIL rnd neuron_idx c=%0d got=%0d want=%0d", c, o_n[c], e_n[c]); end
            end
            total++;
            if (macs != ANN * AN) begin bad++; $display("FAIL rnd mac_count got=%0d want=%0d", macs, ANN * AN); end
        end
    endtask

    task automatic test_min_config();
        int done_at;
        for (int pass = 0; pass < 2; pass++) begin
            gen_stim(pass * 2, pass * 2);
            build_model(BN, BNN, BPL, 0);
            run_b(e_len);
            done_at = -1;
            for (int c = 0; c < e_len; c++) begin
                if (o_ctl[c][1] === 1'b1 && done_at < 0) done_at = c;
                total++;
                if (o_ctl[c] !== e_ctl[c]) begin bad++; $display("FAIL min ctl c=%0d got=%b want=%b", c, o_ctl[c], e_ctl[c]); end
                if (e_wchk[c]) begin
                    total++;
                    if (o_w[c] !== e_w[c]) begin bad++; $display("FAIL min w_addr c=%0d got=%0d want=%0d", c, o_w[c], e_w[c]); end
                end
            end
            if (pass == 0) begin
                total++;
                if (done_at != 1 + BNN * (BN + BPL + 4)) begin
                    bad++; $display("FAIL min done_cycle got=%0d want=%0d", done_at, 1 + BNN * (BN + BPL + 4));
                end
            end
        end
    endtask

    initial begin
        bus_a.start = 1'b0; bus_a.x_valid = 1'b0; bus_a.out_ready = 1'b0;
        bus_b.start = 1'b0; bus_b.x_valid = 1'b0; bus_b.out_ready = 1'b0;
        test_reset();
        test_abort();
        test_continuous();
        test_gapped_input();
        test_out_backpressure();
        test_ignored_inputs();
        test_min_config();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
